// File: rtl/controle_execucao_pkg.sv
// Shared types and default parameters for the execution controller.
package controle_execucao_pkg;

    localparam int unsigned QW_DEF           = 16;
    localparam int unsigned QUANTUM_INIT_DEF = 1000;
    localparam int unsigned DEB_CYCLES_DEF   = 4;
    localparam int unsigned EW               = 3;

    typedef enum logic [EW-1:0] {
        INICIO     = 3'd0,
        EXECUTA    = 3'd1,
        AGUARDA_IN = 3'd2,
        RETOMA     = 3'd3,
        TROCA      = 3'd4,
        PARADO     = 3'd5
    } estado_e;

endpackage

// File: rtl/controle_execucao_if.sv
// Control/status bundle between the CPU/OS side and the execution controller.
interface controle_execucao_if
    import controle_execucao_pkg::*;
#(
    parameter int unsigned QW = QW_DEF
);
    logic          botao_in;
    logic          pausa;
    logic          halt_instr;
    logic          quantum_en;
    logic          quantum_load;
    logic [QW-1:0] quantum_valor;
    logic          troca_ack;
    logic          cpu_enable;
    logic          status;
    logic          in_valido;
    logic          troca_req;
    logic [EW-1:0] estado;

    modport master (
        output botao_in, pausa, halt_instr, quantum_en, quantum_load, quantum_valor, troca_ack,
        input  cpu_enable, status, in_valido, troca_req, estado
    );

    modport slave (
        input  botao_in, pausa, halt_instr, quantum_en, quantum_load, quantum_valor, troca_ack,
        output cpu_enable, status, in_valido, troca_req, estado
    );
endinterface

// File: rtl/controle_execucao_filtro_botao.sv
// Button conditioner: 2-flop synchroniser, consecutive-sample debounce, press pulse.
module filtro_botao
    import controle_execucao_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_botao,
    output logic o_pulso
);
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_estavel;
    logic          r_pulso;
    logic [CW-1:0] r_cnt;

    // Count samples differing from the accepted level; accept after DEB_CYCLES in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_estavel <= 1'b0;
            r_pulso   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_botao;
            r_sync2 <= r_sync1;
            r_pulso <= 1'b0;
            if (r_sync2 == r_estavel) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_estavel <= r_sync2;
                r_cnt     <= '0;
                r_pulso   <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_pulso = r_pulso;

endmodule

// File: rtl/controle_execucao.sv
// Execution controller: run/stall sequencing for IN pause, HALT and quantum preemption.
module controle_execucao
    import controle_execucao_pkg::*;
#(
    parameter int unsigned QW           = QW_DEF,
    parameter int unsigned QUANTUM_INIT = QUANTUM_INIT_DEF,
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    controle_execucao_if.slave  bus
);
    estado_e       r_estado;
    estado_e       w_prox;
    logic [QW-1:0] r_cnt;
    logic [QW-1:0] r_recarga;
    logic [QW-1:0] w_cnt_prox;
    logic          w_pulso;
    logic          w_decrementa;
    logic          w_expira;
    logic          w_cpu_en;
    logic          w_status;
    logic          w_in_valido;
    logic          w_troca_req;
    logic          r_cpu_en;
    logic          r_status;
    logic          r_in_valido;
    logic          r_troca_req;

    filtro_botao #(.DEB_CYCLES(DEB_CYCLES)) u_filtro (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_botao (bus.botao_in),
        .o_pulso (w_pulso)
    );

    // Quantum bookkeeping; a load overrides decrement and reload but not the expiry decision
    always_comb begin
        w_decrementa = (r_estado == EXECUTA) && bus.quantum_en && (r_cnt != '0);
        w_expira     = w_decrementa && (r_cnt == QW'(1));
        w_cnt_prox   = r_cnt;
        if (w_decrementa) begin
            w_cnt_prox = r_cnt - QW'(1);
        end
        if ((r_estado == TROCA) && bus.troca_ack) begin
            w_cnt_prox = r_recarga;
        end
        if (bus.quantum_load) begin
            w_cnt_prox = bus.quantum_valor;
        end
    end

    // Next state and next-state output decode
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIO:     w_prox = EXECUTA;
            EXECUTA: begin
                if (bus.halt_instr)  w_prox = PARADO;
                else if (bus.pausa)  w_prox = AGUARDA_IN;
                else if (w_expira)   w_prox = TROCA;
            end
            AGUARDA_IN: if (w_pulso)       w_prox = RETOMA;
            RETOMA:     w_prox = EXECUTA;
            TROCA:      if (bus.troca_ack) w_prox = EXECUTA;
            PARADO:     if (w_pulso)       w_prox = RETOMA;
            default:    w_prox = INICIO;
        endcase
        w_cpu_en    = (w_prox == EXECUTA) || (w_prox == RETOMA);
        w_status    = (w_prox == AGUARDA_IN) || (w_prox == PARADO);
        w_in_valido = (w_prox == RETOMA);
        w_troca_req = (w_prox == TROCA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= INICIO;
            r_cnt       <= QW'(QUANTUM_INIT);
            r_recarga   <= QW'(QUANTUM_INIT);
            r_cpu_en    <= 1'b0;
            r_status    <= 1'b0;
            r_in_valido <= 1'b0;
            r_troca_req <= 1'b0;
        end else begin
            r_estado    <= w_prox;
            r_cnt       <= w_cnt_prox;
            if (bus.quantum_load) begin
                r_recarga <= bus.quantum_valor;
            end
            r_cpu_en    <= w_cpu_en;
            r_status    <= w_status;
            r_in_valido <= w_in_valido;
            r_troca_req <= w_troca_req;
        end
    end

    assign bus.cpu_enable = r_cpu_en;
    assign bus.status     = r_status;
    assign bus.in_valido  = r_in_valido;
    assign bus.troca_req  = r_troca_req;
    assign bus.estado     = r_estado;

endmodule

// File: tb/tb_controle_execucao.sv
// Directed + randomized bench for controle_execucao against a spec-level reference model.
module tb_controle_execucao;

    localparam int DEB   = 4;
    localparam int QINIT = 1000;
    localparam int S_INICIO = 0, S_EXEC = 1, S_AGUARDA = 2, S_RETOMA = 3, S_TROCA = 4, S_PARADO = 5;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    controle_execucao_if u_if ();

    controle_execucao dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int m_st;
    int m_cnt;
    int m_rec;
    bit m_acc;
    bit m_pulse;
    bit hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = S_INICIO;
        m_cnt   = QINIT;
        m_rec   = QINIT;
        m_acc   = 1'b0;
        m_pulse = 1'b0;
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
    endtask

    // One clock of spec behaviour using the inputs held across the edge
    task automatic model_update();
        int  nst;
        int  ncnt;
        bit  pulse_seen;
        bit  flip;
        bit  dec;
        pulse_seen = m_pulse;
        hist.push_front(u_if.botao_in);
        void'(hist.pop_back());
        flip = 1'b1;
        for (int i = 2; i < DEB + 2; i++) if (hist[i] == m_acc) flip = 1'b0;
        m_pulse = 1'b0;
        if (flip) begin
            m_acc   = !m_acc;
            m_pulse = m_acc;
        end
        dec  = (m_st == S_EXEC) && u_if.quantum_en && (m_cnt > 0);
        nst  = m_st;
        case (m_st)
            S_INICIO:  nst = S_EXEC;
            S_EXEC:    nst = u_if.halt_instr ? S_PARADO : u_if.pausa ? S_AGUARDA :
                             (dec && m_cnt == 1) ? S_TROCA : S_EXEC;
            S_AGUARDA: nst = pulse_seen ? S_RETOMA : S_AGUARDA;
            S_RETOMA:  nst = S_EXEC;
            S_TROCA:   nst = u_if.troca_ack ? S_EXEC : S_TROCA;
            S_PARADO:  nst = pulse_seen ? S_RETOMA : S_PARADO;
            default:   nst = S_INICIO;
        endcase
        ncnt = dec ? m_cnt - 1 : m_cnt;
        if (m_st == S_TROCA && u_if.troca_ack) ncnt = m_rec;
        if (u_if.quantum_load) begin
            ncnt  = int'(u_if.quantum_valor);
            m_rec = int'(u_if.quantum_valor);
        end
        m_st  = nst;
        m_cnt = ncnt;
    endtask

    task automatic check_outputs();
        chk("estado",     32'(u_if.estado),     32'(m_st));
        chk("cpu_enable", 32'(u_if.cpu_enable), 32'(m_st == S_EXEC || m_st == S_RETOMA));
        chk("status",     32'(u_if.status),     32'(m_st == S_AGUARDA || m_st == S_PARADO));
        chk("in_valido",  32'(u_if.in_valido),  32'(m_st == S_RETOMA));
        chk("troca_req",  32'(u_if.troca_req),  32'(m_st == S_TROCA));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    // Hold the button for n cycles, dropping pausa once the input is taken, then let it settle low
    task automatic press(input int n, output int n_ret);
        n_ret = 0;
        u_if.botao_in = 1'b1;
        repeat (n) begin
            tick();
            if (u_if.in_valido) begin
                n_ret++;
                u_if.pausa = 1'b0;
            end
        end
        u_if.botao_in = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    initial begin
        int k;
        int lat;
        int n_exe;
        int n_ret;
        int n_troca;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        u_if.botao_in = 1'b0; u_if.pausa = 1'b0; u_if.halt_instr = 1'b0;
        u_if.quantum_en = 1'b0; u_if.quantum_load = 1'b0; u_if.quantum_valor = '0;
        u_if.troca_ack = 1'b0;
        model_reset();

        // Reset state, then INICIO for one cycle and EXECUTA
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        chk("inicio_hold", 32'(u_if.estado), 32'(S_INICIO));
        tick();
        chk("exec_after_reset", 32'(u_if.cpu_enable), 32'd1);

        // IN pause: latency from button rise to RETOMA
        u_if.pausa = 1'b1;
        tick();
        u_if.botao_in = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (u_if.in_valido && lat == 0) begin
                lat = i;
                u_if.pausa = 1'b0;
            end
        end
        u_if.botao_in = 1'b0;
        chk("press_latency", 32'(lat), 32'(DEB + 3));
        repeat (DEB + 4) tick();

        // 3-cycle glitch must not release AGUARDA_IN
        u_if.pausa = 1'b1;
        tick();
        u_if.botao_in = 1'b1;
        repeat (3) tick();
        u_if.botao_in = 1'b0;
        repeat (12) tick();
        chk("glitch_ignored", 32'(u_if.estado), 32'(S_AGUARDA));
        press(10, n_ret);
        chk("glitch_then_press", 32'(n_ret), 32'd1);

        // Quantum of 5: five EXECUTA cycles, then TROCA
        u_if.quantum_en = 1'b1; u_if.quantum_load = 1'b1; u_if.quantum_valor = 16'd5;
        n_exe = 0;
        k = 0;
        while (k < 20) begin
            tick();
            u_if.quantum_load = 1'b0;
            if (u_if.estado == 3'(S_TROCA)) break;
            if (u_if.estado == 3'(S_EXEC)) n_exe++;
            k++;
        end
        chk("quantum5_exec_cycles", 32'(n_exe), 32'd5);
        chk("quantum5_troca_req", 32'(u_if.troca_req), 32'd1);
        repeat (3) tick();
        u_if.troca_ack = 1'b1;
        tick();
        u_if.troca_ack = 1'b0;
        n_exe = (u_if.estado == 3'(S_EXEC)) ? 1 : 0;
        k = 0;
        while (k < 20) begin
            tick();
            if (u_if.estado == 3'(S_TROCA)) break;
            if (u_if.estado == 3'(S_EXEC)) n_exe++;
            k++;
        end
        chk("reload_exec_cycles", 32'(n_exe), 32'd5);

        // halt and pausa together with counter at 1: halt wins
        u_if.troca_ack = 1'b1;
        tick();
        u_if.troca_ack = 1'b0;
        repeat (4) tick();
        u_if.halt_instr = 1'b1; u_if.pausa = 1'b1;
        tick();
        chk("halt_wins", 32'(u_if.estado), 32'(S_PARADO));
        u_if.halt_instr = 1'b0; u_if.pausa = 1'b0;
        press(10, n_ret);
        chk("parado_resume", 32'(n_ret), 32'd1);

        // Zero quantum disables preemption
        u_if.quantum_load = 1'b1; u_if.quantum_valor = 16'd0;
        tick();
        u_if.quantum_load = 1'b0;
        n_troca = 0;
        repeat (2000) begin
            tick();
            if (u_if.troca_req) n_troca++;
        end
        chk("zero_quantum_no_troca", 32'(n_troca), 32'd0);

        // Held button yields exactly one RETOMA
        u_if.pausa = 1'b1;
        tick();
        press(50, n_ret);
        chk("held_one_retoma", 32'(n_ret), 32'd1);

        // Press during TROCA is discarded
        u_if.quantum_load = 1'b1; u_if.quantum_valor = 16'd3;
        tick();
        u_if.quantum_load = 1'b0;
        k = 0;
        while (k < 10 && u_if.estado != 3'(S_TROCA)) begin
            tick();
            k++;
        end
        chk("troca_reached", 32'(u_if.estado), 32'(S_TROCA));
        u_if.botao_in = 1'b1;
        repeat (10) tick();
        u_if.quantum_en = 1'b0;
        u_if.troca_ack = 1'b1;
        tick();
        u_if.troca_ack = 1'b0;
        u_if.botao_in = 1'b0;
        repeat (DEB + 4) tick();
        u_if.pausa = 1'b1;
        repeat (20) tick();
        chk("press_not_queued", 32'(u_if.estado), 32'(S_AGUARDA));
        press(10, n_ret);

        // Reset during TROCA drops troca_req asynchronously
        u_if.quantum_en = 1'b1; u_if.quantum_load = 1'b1; u_if.quantum_valor = 16'd2;
        tick();
        u_if.quantum_load = 1'b0;
        k = 0;
        while (k < 10 && u_if.estado != 3'(S_TROCA)) begin
            tick();
            k++;
        end
        chk("troca_before_reset", 32'(u_if.troca_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_troca_req", 32'(u_if.troca_req), 32'd0);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("inicio_after_abort", 32'(u_if.estado), 32'(S_INICIO));
        tick();

        // Randomized traffic against the model
        repeat (600) begin
            u_if.halt_instr   = ($urandom % 16) == 0;
            u_if.pausa        = ($urandom % 6) == 0;
            u_if.troca_ack    = ($urandom % 3) == 0;
            u_if.quantum_load = ($urandom % 20) == 0;
            u_if.quantum_valor = 16'($urandom_range(0, 8));
            if (($urandom % 30) == 0) u_if.quantum_en = ~u_if.quantum_en;
            if (($urandom % 8) == 0)  u_if.botao_in   = ~u_if.botao_in;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
